// File: rtl/seq_stream_ctrl.sv
// Serializes valid/ready words MSB-first onto a sequence detector and counts its hits.
// Latency: start -> CLEAR (1 cycle) -> LOAD; each bit lasts div_q+1 cycles; done pulses after the last bit.
// Backpressure: s_ready is high only in LOAD; the FSM waits there indefinitely, prescaler frozen.
module seq_stream_ctrl #(
  parameter int W     = 8,
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       word_count,
  input  logic [DIV_W-1:0] div_val,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             det_din,
  output logic             det_step,
  output logic             det_clr,
  input  logic             det_hit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             overflow
);

  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    SHIFT  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       words_left;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pcnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [W-1:0]     shreg;

  // Bit-period boundary: only meaningful in SHIFT; the prescaler is held elsewhere.
  logic step;
  logic last_bit;
  assign step     = (state_q == SHIFT) && (pcnt == div_q);
  assign last_bit = (bit_cnt == LAST_BIT);

  // Outputs are pure decodes of registered state, so nothing combinational reaches them from s_valid or det_hit.
  assign s_ready  = (state_q == LOAD);
  assign det_clr  = (state_q == CLEAR);
  assign done     = (state_q == FINISH);
  assign busy     = (state_q != IDLE);
  assign det_step = step;
  assign det_din  = (state_q == SHIFT) && shreg[W-1];

  // State register; reset drops straight to IDLE, which silences every decoded output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the run sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR:  state_d = (words_left == 8'd0) ? FINISH : LOAD;
      LOAD:   if (s_valid) state_d = SHIFT;
      SHIFT: begin
        // words_left is never zero here: CLEAR diverts empty runs straight to FINISH.
        if (step && last_bit) state_d = (words_left == 8'd1) ? FINISH : LOAD;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: run parameters, word shifter, prescaler, bit counter and hit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_left <= '0;
      div_q      <= '0;
      pcnt       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      match_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            words_left <= word_count;
            div_q      <= div_val;
            match_cnt  <= '0;
            overflow   <= 1'b0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            shreg   <= s_data;
            bit_cnt <= '0;
            pcnt    <= '0;
          end
        end
        SHIFT: begin
          if (step) begin
            pcnt    <= '0;
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (det_hit) begin
              // Saturate rather than wrap; any hit lost to saturation is flagged sticky.
              if (match_cnt == CNT_MAX) overflow <= 1'b1;
              else                      match_cnt <= match_cnt + 1'b1;
            end
            if (last_bit) words_left <= words_left - 8'd1;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench for seq_stream_ctrl: two instances (8-bit and 4-bit hit counters) on shared stimulus.
// The detector is modelled as det_hit = det_din & det_step.
// Inputs change 1 time unit after the rising edge, and outputs are sampled there too.
module tb_seq_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  word_count;
  logic [15:0] div_val;
  logic [7:0]  s_data;
  logic        s_valid;

  logic        s_ready, det_din, det_step, det_clr, det_hit, busy, done, overflow;
  logic [7:0]  match_cnt;

  logic        s_ready2, det_din2, det_step2, det_clr2, det_hit2, busy2, done2, overflow2;
  logic [3:0]  match_cnt2;

  int nerr;
  int nchk;
  int steps;

  assign det_hit  = det_din & det_step;
  assign det_hit2 = det_din2 & det_step2;

  seq_stream_ctrl #(.W(8), .DIV_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .div_val(div_val),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .det_din(det_din),
    .det_step(det_step), .det_clr(det_clr), .det_hit(det_hit), .busy(busy),
    .done(done), .match_cnt(match_cnt), .overflow(overflow)
  );

  seq_stream_ctrl #(.W(8), .DIV_W(16), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .div_val(div_val),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2), .det_din(det_din2),
    .det_step(det_step2), .det_clr(det_clr2), .det_hit(det_hit2), .busy(busy2),
    .done(done2), .match_cnt(match_cnt2), .overflow(overflow2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full word in SHIFT: step only on the last cycle of each bit period, din = MSB-first bits.
  task automatic shift_word(input logic [7:0] w, input int dq);
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k <= dq; k++) begin
        chk("step", {31'd0, det_step}, {31'd0, (k == dq)});
        chk("din", {31'd0, det_din}, {31'd0, w[7-b]});
        chk("sready_in_shift", {31'd0, s_ready}, 32'd0);
        chk("done_in_shift", {31'd0, done}, 32'd0);
        if (det_step === 1'b1) steps++;
        tick();
      end
    end
  endtask

  task automatic do_start(input logic [7:0] wc, input logic [15:0] dv);
    word_count = wc;
    div_val    = dv;
    start      = 1'b1;
    tick();               // edge 0 samples start; now in cycle 1
    start      = 1'b0;
  endtask

  initial begin
    nerr = 0; nchk = 0; steps = 0;
    rst = 1'b1; start = 1'b0; word_count = 8'd0; div_val = 16'd0;
    s_data = 8'd0; s_valid = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sready", {31'd0, s_ready}, 32'd0);
    chk("rst_step", {31'd0, det_step}, 32'd0);
    chk("rst_clr", {31'd0, det_clr}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_din", {31'd0, det_din}, 32'd0);
    chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_step", {31'd0, det_step}, 32'd0);

    // Single word 0xA5, div 0: steps in cycles 3..10, done in 11, 4 hits
    s_data = 8'hA5; s_valid = 1'b1;
    do_start(8'd1, 16'd0);
    chk("t1_c1_clr", {31'd0, det_clr}, 32'd1);
    chk("t1_c1_busy", {31'd0, busy}, 32'd1);
    chk("t1_c1_sready", {31'd0, s_ready}, 32'd0);
    tick();
    chk("t1_c2_sready", {31'd0, s_ready}, 32'd1);
    chk("t1_c2_clr", {31'd0, det_clr}, 32'd0);
    chk("t1_c2_step", {31'd0, det_step}, 32'd0);
    tick();
    s_valid = 1'b0;
    steps = 0;
    shift_word(8'hA5, 0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_cnt", {24'd0, match_cnt}, 32'd4);
    chk("t1_steps", steps, 32'd8);
    tick();
    chk("t1_done_gone", {31'd0, done}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_cnt_hold", {24'd0, match_cnt}, 32'd4);

    // Two words 0xFF, 0x00 at div 3: 16 steps, 8 hits, LOAD in cycle 35, done in 68
    s_data = 8'hFF; s_valid = 1'b1;
    do_start(8'd2, 16'd3);
    tick();
    chk("t2_load0", {31'd0, s_ready}, 32'd1);
    tick();
    s_data = 8'h00;
    steps = 0;
    shift_word(8'hFF, 3);
    chk("t2_load1", {31'd0, s_ready}, 32'd1);
    chk("t2_load1_step", {31'd0, det_step}, 32'd0);
    chk("t2_mid_cnt", {24'd0, match_cnt}, 32'd8);
    tick();
    s_valid = 1'b0;
    shift_word(8'h00, 3);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_cnt", {24'd0, match_cnt}, 32'd8);
    chk("t2_steps", steps, 32'd16);
    tick();
    chk("t2_done_once", {31'd0, done}, 32'd0);
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // Producer stall: 5 LOAD cycles without s_valid, then 0x3C at div 1
    s_data = 8'h3C; s_valid = 1'b0;
    do_start(8'd1, 16'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_sready", {31'd0, s_ready}, 32'd1);
      chk("t3_stall_step", {31'd0, det_step}, 32'd0);
      tick();
    end
    chk("t3_still_load", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    steps = 0;
    shift_word(8'h3C, 1);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_cnt", {24'd0, match_cnt}, 32'd4);
    tick();

    // Saturation on the 4-bit counter: three 0xFF words, 24 hits
    s_data = 8'hFF; s_valid = 1'b1;
    do_start(8'd3, 16'd0);
    tick();
    tick();
    shift_word(8'hFF, 0);
    chk("t4_w0_cnt", {28'd0, match_cnt2}, 32'd8);
    chk("t4_w0_ovf", {31'd0, overflow2}, 32'd0);
    tick();
    shift_word(8'hFF, 0);
    chk("t4_w1_cnt", {28'd0, match_cnt2}, 32'd15);
    chk("t4_w1_ovf", {31'd0, overflow2}, 32'd1);
    tick();
    s_valid = 1'b0;
    shift_word(8'hFF, 0);
    chk("t4_done", {31'd0, done2}, 32'd1);
    chk("t4_cnt_sat", {28'd0, match_cnt2}, 32'd15);
    chk("t4_ovf", {31'd0, overflow2}, 32'd1);
    chk("t4_wide_cnt", {24'd0, match_cnt}, 32'd24);
    chk("t4_wide_ovf", {31'd0, overflow}, 32'd0);
    tick();
    tick();
    chk("t4_ovf_hold", {31'd0, overflow2}, 32'd1);

    // Empty run: clr in cycle 1, done in cycle 2, s_ready never high even with s_valid
    s_valid = 1'b1;
    do_start(8'd0, 16'd0);
    chk("t5_clr", {31'd0, det_clr}, 32'd1);
    chk("t5_c1_sready", {31'd0, s_ready}, 32'd0);
    chk("t5_cnt_cleared", {28'd0, match_cnt2}, 32'd0);
    chk("t5_ovf_cleared", {31'd0, overflow2}, 32'd0);
    tick();
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_c2_sready", {31'd0, s_ready}, 32'd0);
    chk("t5_cnt", {24'd0, match_cnt}, 32'd0);
    tick();
    chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_c3_sready", {31'd0, s_ready}, 32'd0);

    // start during SHIFT is ignored; rst mid-SHIFT clears outputs at once
    s_data = 8'hF0; s_valid = 1'b1;
    do_start(8'd2, 16'd2);
    tick();
    tick();
    s_valid = 1'b0;
    tick();                       // cycle 4
    word_count = 8'd0;
    start = 1'b1;
    tick();                       // cycle 5: first step of the original run
    start = 1'b0;
    chk("t6_step", {31'd0, det_step}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_no_clr", {31'd0, det_clr}, 32'd0);
    chk("t6_din", {31'd0, det_din}, 32'd1);
    tick();
    chk("t6_cnt", {24'd0, match_cnt}, 32'd1);
    chk("t6_no_done", {31'd0, done}, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_din", {31'd0, det_din}, 32'd0);
    chk("t6_rst_step", {31'd0, det_step}, 32'd0);
    chk("t6_rst_cnt", {24'd0, match_cnt}, 32'd0);
    chk("t6_rst_sready", {31'd0, s_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_step", {31'd0, det_step}, 32'd0);
    chk("t6_post_idle", {31'd0, busy}, 32'd0);

    // Fresh run after reset: 0x81 at div 0, 2 hits
    s_data = 8'h81; s_valid = 1'b1;
    do_start(8'd1, 16'd0);
    chk("t6b_clr", {31'd0, det_clr}, 32'd1);
    tick();
    tick();
    s_valid = 1'b0;
    shift_word(8'h81, 0);
    chk("t6b_done", {31'd0, done}, 32'd1);
    chk("t6b_cnt", {24'd0, match_cnt}, 32'd2);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
